// File: rtl/r_channel_router.sv
// Routes three slave AXI R channels to two masters one burst at a time using IDS[MID_MSB:MID_LSB]; IDS[3:0] becomes RID.
// One grant bubble, then zero-latency forwarding under master backpressure; define R_ROUTER_RR_EN for round-robin arbitration.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module r_channel_router #(
  parameter int MID_MSB = 7,
  parameter int MID_LSB = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`AXI_IDS_BITS-1:0]  S0_IDS,
  input  logic [`AXI_IDS_BITS-1:0]  S1_IDS,
  input  logic [`AXI_IDS_BITS-1:0]  S2_IDS,
  input  logic [`AXI_DATA_BITS-1:0] S0_Data,
  input  logic [`AXI_DATA_BITS-1:0] S1_Data,
  input  logic [`AXI_DATA_BITS-1:0] S2_Data,
  input  logic [1:0]                S0_Resp,
  input  logic [1:0]                S1_Resp,
  input  logic [1:0]                S2_Resp,
  input  logic                      S0_Last,
  input  logic                      S1_Last,
  input  logic                      S2_Last,
  input  logic                      S0_Valid,
  input  logic                      S1_Valid,
  input  logic                      S2_Valid,
  output logic                      S0_Ready,
  output logic                      S1_Ready,
  output logic                      S2_Ready,
  output logic [`AXI_ID_BITS-1:0]   M0_ID,
  output logic [`AXI_ID_BITS-1:0]   M1_ID,
  output logic [`AXI_DATA_BITS-1:0] M0_Data,
  output logic [`AXI_DATA_BITS-1:0] M1_Data,
  output logic [1:0]                M0_Resp,
  output logic [1:0]                M1_Resp,
  output logic                      M0_Last,
  output logic                      M1_Last,
  output logic                      M0_Valid,
  output logic                      M1_Valid,
  input  logic                      M0_Ready,
  input  logic                      M1_Ready,
  output logic                      busy,
  output logic                      unroute_err
);
  localparam int MW = MID_MSB - MID_LSB + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [1:0]                grant;
  logic [1:0]                pick;
  logic [MW-1:0]             dest;
  logic [MW-1:0]             pick_mid;
  logic [`AXI_ID_BITS-1:0]   g_id;
  logic [`AXI_DATA_BITS-1:0] g_data;
  logic [1:0]                g_resp;
  logic                      g_last;
  logic                      g_valid;
  logic                      g_ready;
  logic                      mapped;
`ifdef R_ROUTER_RR_EN
  logic [1:0]                rr_ptr;
`endif

  // Arbitration among slaves presenting a valid beat while idle.
  always_comb begin
    pick = 2'd0;
`ifdef R_ROUTER_RR_EN
    case (rr_ptr)
      2'd1:    pick = S1_Valid ? 2'd1 : (S2_Valid ? 2'd2 : 2'd0);
      2'd2:    pick = S2_Valid ? 2'd2 : (S0_Valid ? 2'd0 : 2'd1);
      default: pick = S0_Valid ? 2'd0 : (S1_Valid ? 2'd1 : 2'd2);
    endcase
`else
    pick = S0_Valid ? 2'd0 : (S1_Valid ? 2'd1 : 2'd2);
`endif
  end

  always_comb begin
    case (pick)
      2'd1:    pick_mid = S1_IDS[MID_MSB:MID_LSB];
      2'd2:    pick_mid = S2_IDS[MID_MSB:MID_LSB];
      default: pick_mid = S0_IDS[MID_MSB:MID_LSB];
    endcase
  end

  always_comb begin
    case (grant)
      2'd1: begin
        g_id = S1_IDS[`AXI_ID_BITS-1:0]; g_data = S1_Data; g_resp = S1_Resp;
        g_last = S1_Last; g_valid = S1_Valid;
      end
      2'd2: begin
        g_id = S2_IDS[`AXI_ID_BITS-1:0]; g_data = S2_Data; g_resp = S2_Resp;
        g_last = S2_Last; g_valid = S2_Valid;
      end
      default: begin
        g_id = S0_IDS[`AXI_ID_BITS-1:0]; g_data = S0_Data; g_resp = S0_Resp;
        g_last = S0_Last; g_valid = S0_Valid;
      end
    endcase
  end

  assign mapped = (dest == MW'(0)) || (dest == MW'(1));

  // Unmapped bursts are sunk with Ready held high so the slave can drain.
  always_comb begin
    M0_ID = '0; M0_Data = '0; M0_Resp = '0; M0_Last = 1'b0; M0_Valid = 1'b0;
    M1_ID = '0; M1_Data = '0; M1_Resp = '0; M1_Last = 1'b0; M1_Valid = 1'b0;
    S0_Ready = 1'b0; S1_Ready = 1'b0; S2_Ready = 1'b0;
    g_ready = 1'b0;
    if (state == BUSY) begin
      if (dest == MW'(0)) begin
        M0_ID = g_id; M0_Data = g_data; M0_Resp = g_resp; M0_Last = g_last; M0_Valid = g_valid;
        g_ready = M0_Ready;
      end else if (dest == MW'(1)) begin
        M1_ID = g_id; M1_Data = g_data; M1_Resp = g_resp; M1_Last = g_last; M1_Valid = g_valid;
        g_ready = M1_Ready;
      end else begin
        g_ready = 1'b1;
      end
      case (grant)
        2'd1:    S1_Ready = g_ready;
        2'd2:    S2_Ready = g_ready;
        default: S0_Ready = g_ready;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'd0;
      dest        <= '0;
      busy        <= 1'b0;
      unroute_err <= 1'b0;
`ifdef R_ROUTER_RR_EN
      rr_ptr      <= 2'd0;
`endif
    end else begin
      unroute_err <= 1'b0;
      case (state)
        IDLE: begin
          if (S0_Valid || S1_Valid || S2_Valid) begin
            grant <= pick;
            dest  <= pick_mid;
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (g_valid && g_ready && g_last) begin
            state       <= IDLE;
            busy        <= 1'b0;
            unroute_err <= !mapped;
`ifdef R_ROUTER_RR_EN
            rr_ptr      <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_r_channel_router.sv
// Directed bench for r_channel_router: behavioural slaves feed bursts, a scoreboard checks every master handshake.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module tb_r_channel_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [`AXI_IDS_BITS-1:0]  S0_IDS, S1_IDS, S2_IDS;
  logic [`AXI_DATA_BITS-1:0] S0_Data, S1_Data, S2_Data;
  logic [1:0]                S0_Resp, S1_Resp, S2_Resp;
  logic                      S0_Last, S1_Last, S2_Last;
  logic                      S0_Valid, S1_Valid, S2_Valid;
  logic                      S0_Ready, S1_Ready, S2_Ready;
  logic [`AXI_ID_BITS-1:0]   M0_ID, M1_ID;
  logic [`AXI_DATA_BITS-1:0] M0_Data, M1_Data;
  logic [1:0]                M0_Resp, M1_Resp;
  logic                      M0_Last, M1_Last, M0_Valid, M1_Valid;
  logic                      M0_Ready = 1'b0, M1_Ready = 1'b0;
  logic                      busy, unroute_err;

  r_channel_router dut (
    .clk(clk), .rst(rst),
    .S0_IDS(S0_IDS), .S1_IDS(S1_IDS), .S2_IDS(S2_IDS),
    .S0_Data(S0_Data), .S1_Data(S1_Data), .S2_Data(S2_Data),
    .S0_Resp(S0_Resp), .S1_Resp(S1_Resp), .S2_Resp(S2_Resp),
    .S0_Last(S0_Last), .S1_Last(S1_Last), .S2_Last(S2_Last),
    .S0_Valid(S0_Valid), .S1_Valid(S1_Valid), .S2_Valid(S2_Valid),
    .S0_Ready(S0_Ready), .S1_Ready(S1_Ready), .S2_Ready(S2_Ready),
    .M0_ID(M0_ID), .M1_ID(M1_ID), .M0_Data(M0_Data), .M1_Data(M1_Data),
    .M0_Resp(M0_Resp), .M1_Resp(M1_Resp), .M0_Last(M0_Last), .M1_Last(M1_Last),
    .M0_Valid(M0_Valid), .M1_Valid(M1_Valid), .M0_Ready(M0_Ready), .M1_Ready(M1_Ready),
    .busy(busy), .unroute_err(unroute_err)
  );

  typedef struct packed {
    logic [7:0]  ids;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } sbeat_t;

  typedef struct packed {
    logic        m;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  sbeat_t sbuf [3][32];
  int     head [3];
  int     tail [3];
  logic   hs   [3];
  exp_t   sb   [$];
  int     n_asrt = 0;
  int     n_fail = 0;

  logic [7:0]  sids  [3];
  logic [31:0] sdata [3];
  logic [1:0]  sresp [3];
  logic        slast [3];
  logic        sv    [3];

  assign S0_IDS = sids[0];   assign S1_IDS = sids[1];   assign S2_IDS = sids[2];
  assign S0_Data = sdata[0]; assign S1_Data = sdata[1]; assign S2_Data = sdata[2];
  assign S0_Resp = sresp[0]; assign S1_Resp = sresp[1]; assign S2_Resp = sresp[2];
  assign S0_Last = slast[0]; assign S1_Last = slast[1]; assign S2_Last = slast[2];
  assign S0_Valid = sv[0];   assign S1_Valid = sv[1];   assign S2_Valid = sv[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (head[i] < tail[i]) begin
        sv[i] = 1'b1; sids[i] = sbuf[i][head[i]].ids; sdata[i] = sbuf[i][head[i]].data;
        sresp[i] = sbuf[i][head[i]].resp; slast[i] = sbuf[i][head[i]].last;
      end else begin
        sv[i] = 1'b0; sids[i] = '0; sdata[i] = '0; sresp[i] = '0; slast[i] = 1'b0;
      end
    end
  endtask

  // Queue a burst on a slave; beats bound for a real master are expected in call order.
  task automatic send(input int s, input logic [7:0] ids, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      sbuf[s][tail[s]] = '{ids, base + 32'(b), 2'(b), (b == n - 1)};
      tail[s]++;
      if (ids[7:4] < 4'd2) sb.push_back('{ids[4], ids[3:0], base + 32'(b), 2'(b), (b == n - 1)});
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      head[i] = tail[i];
      hs[i] = 1'b0;
    end
    drive();
    sb.delete();
  endtask

  task automatic check_beat(input logic m);
    exp_t e;
    if (sb.size() == 0) begin
      n_asrt++;
      n_fail++;
      $error("FAIL sb_unexpected beat on M%0d data=%0h expected=none", m, m ? M1_Data : M0_Data);
    end else begin
      e = sb.pop_front();
      chk("sb_master", m, e.m);
      chk("sb_id", m ? M1_ID : M0_ID, e.id);
      chk("sb_data", m ? M1_Data : M0_Data, e.data);
      chk("sb_resp", m ? M1_Resp : M0_Resp, e.resp);
      chk("sb_last", m ? M1_Last : M0_Last, e.last);
    end
  endtask

  task automatic observe();
    chk("both_m_valid", M0_Valid & M1_Valid, 0);
    if (M0_Valid && M0_Ready) check_beat(1'b0);
    if (M1_Valid && M1_Ready) check_beat(1'b1);
    hs[0] = sv[0] & S0_Ready;
    hs[1] = sv[1] & S1_Ready;
    hs[2] = sv[2] & S2_Ready;
  endtask

  // One clock: slaves retire beats accepted at the edge, drive the next beat, then outputs are checked.
  task automatic cyc(input logic r0, input logic r1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (hs[i]) head[i]++;
    drive();
    M0_Ready = r0;
    M1_Ready = r1;
    #1;
    observe();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hs[i] = 1'b0;
    drive();

    // Reset state
    cyc(1, 1);
    cyc(1, 1);
    chk("rst_m0", {M0_ID, M0_Data, M0_Resp, M0_Last, M0_Valid}, 0);
    chk("rst_m1", {M1_ID, M1_Data, M1_Resp, M1_Last, M1_Valid}, 0);
    chk("rst_sready", {S0_Ready, S1_Ready, S2_Ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unroute", unroute_err, 0);
    rst = 1'b0;

    // S1 4-beat burst to M1
    send(1, 8'h13, 4, 32'd1);
    cyc(1, 1);
    chk("t1_bubble_m1v", M1_Valid, 0);
    chk("t1_bubble_busy", busy, 0);
    for (int b = 1; b <= 4; b++) begin
      cyc(1, 1);
      chk("t1_m1v", M1_Valid, 1);
      chk("t1_id", M1_ID, 4'h3);
      chk("t1_data", M1_Data, b);
      chk("t1_last", M1_Last, (b == 4));
      chk("t1_m0v", M0_Valid, 0);
      chk("t1_busy", busy, 1);
    end
    cyc(1, 1);
    chk("t1_busy_fall", busy, 0);
    chk("t1_m1v_after", M1_Valid, 0);

    // S0 2-beat burst to M0 with master backpressure
    send(0, 8'h05, 2, 32'h100);
    cyc(1, 1);
    cyc(1, 1);
    chk("t2_b1_sready", S0_Ready, 1);
    chk("t2_b1_id", M0_ID, 4'h5);
    chk("t2_b1_busy", busy, 1);
    cyc(0, 1);
    chk("t2_stall_sready", S0_Ready, 0);
    chk("t2_stall_m0v", M0_Valid, 1);
    chk("t2_stall_data", M0_Data, 32'h101);
    chk("t2_stall_busy", busy, 1);
    cyc(1, 1);
    chk("t2_b2_sready", S0_Ready, 1);
    chk("t2_b2_data", M0_Data, 32'h101);
    chk("t2_b2_last", M0_Last, 1);
    chk("t2_b2_busy", busy, 1);
    cyc(1, 1);
    chk("t2_done_busy", busy, 0);

    // S2 unmapped burst is sunk regardless of master readiness
    send(2, 8'h27, 3, 32'h200);
    cyc(0, 0);
    for (int b = 0; b < 3; b++) begin
      cyc(0, 0);
      chk("t4_s2ready", S2_Ready, 1);
      chk("t4_mvalid", {M0_Valid, M1_Valid}, 0);
      chk("t4_unroute_early", unroute_err, 0);
    end
    cyc(1, 1);
    chk("t4_unroute_pulse", unroute_err, 1);
    chk("t4_busy", busy, 0);
    cyc(1, 1);
    chk("t4_unroute_clear", unroute_err, 0);

    // S0 and S1 pending together: serialized with one idle cycle between
    send(0, 8'h02, 2, 32'h300);
    send(1, 8'h11, 2, 32'h400);
    cyc(1, 1);
    cyc(1, 1);
    chk("t6_s0_first", M0_Valid, 1);
    chk("t6_s1_held", S1_Ready, 0);
    cyc(1, 1);
    chk("t6_s0_last", M0_Last, 1);
    cyc(1, 1);
    chk("t6_gap_m1v", M1_Valid, 0);
    chk("t6_gap_busy", busy, 0);
    cyc(1, 1);
    chk("t6_s1_first", M1_Valid, 1);
    chk("t6_s1_data", M1_Data, 32'h400);
    cyc(1, 1);
    cyc(1, 1);
    chk("t6_drained", sb.size(), 0);

    // Reset in the middle of a burst
    send(1, 8'h1A, 4, 32'h500);
    cyc(1, 1);
    cyc(1, 1);
    cyc(1, 1);
    chk("t5_sb_left", sb.size(), 2);
    rst = 1'b1;
    cyc(1, 1);
    chk("t5_busy", busy, 0);
    chk("t5_m1", {M1_Valid, M1_Data, M1_ID, M1_Last}, 0);
    chk("t5_sready", {S0_Ready, S1_Ready, S2_Ready}, 0);
    flush();
    rst = 1'b0;
    send(0, 8'h04, 1, 32'h600);
    cyc(1, 1);
    chk("t5_post_bubble", M0_Valid, 0);
    cyc(1, 1);
    chk("t5_post_m0v", M0_Valid, 1);
    chk("t5_post_busy", busy, 1);
    cyc(1, 1);
    chk("t5_post_idle", busy, 0);

    // Reset pulse, then all three slaves valid with single-beat bursts
    rst = 1'b1;
    cyc(1, 1);
    rst = 1'b0;
`ifdef R_ROUTER_RR_EN
    send(0, 8'h01, 1, 32'h700);
    send(1, 8'h12, 1, 32'h710);
    send(2, 8'h03, 1, 32'h720);
    send(0, 8'h01, 1, 32'h701);
`else
    send(0, 8'h01, 1, 32'h700);
    send(0, 8'h01, 1, 32'h701);
    send(1, 8'h12, 1, 32'h710);
    send(2, 8'h03, 1, 32'h720);
`endif
    for (int c = 0; c < 7; c++) cyc(1, 1);
    chk("t3_sb_after7", sb.size(), 1);
    cyc(1, 1);
    chk("t3_sb_after8", sb.size(), 0);
    cyc(1, 1);
    cyc(1, 1);
    chk("final_drained", sb.size(), 0);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/r_channel_router.md
Name: r_channel_router

Overview:
- AXI read-data (R) return path for the bus interconnect. It takes the R channels of three slaves and delivers each burst to one of two masters.
- The destination master comes from the upper nibble of the slave's RIDS; the master sees only the lower nibble as RID.
- Only one slave burst is forwarded at a time. The block locks onto a slave from grant until its RLAST handshake.
- It is the response-side counterpart of the address-channel arbiter, which tags IDS with the master number.

Parameters:
- MID_MSB, 7, MSB of the master-select field inside IDS.
- MID_LSB, 4, LSB of the master-select field inside IDS.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- S0_IDS, S1_IDS, S2_IDS  input  `AXI_IDS_BITS  slave RIDS
- S0_Data, S1_Data, S2_Data  input  `AXI_DATA_BITS  slave RDATA
- S0_Resp, S1_Resp, S2_Resp  input  2  slave RRESP
- S0_Last, S1_Last, S2_Last  input  1  slave RLAST
- S0_Valid, S1_Valid, S2_Valid  input  1  slave RVALID
- S0_Ready, S1_Ready, S2_Ready  output  1  RREADY to slave
- M0_ID, M1_ID  output  `AXI_ID_BITS  RID to master, taken from IDS[3:0]
- M0_Data, M1_Data  output  `AXI_DATA_BITS  RDATA to master
- M0_Resp, M1_Resp  output  2  RRESP to master
- M0_Last, M1_Last  output  1  RLAST to master
- M0_Valid, M1_Valid  output  1  RVALID to master
- M0_Ready, M1_Ready  input  1  master RREADY
- busy  output  1  high while a burst is locked
- unroute_err  output  1  one-cycle pulse when a burst with an unmapped master field completes

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, grant=0, dest=0, rr_ptr=0.
  - Every Valid, Ready, Data, Resp, ID and Last output is 0; busy=0, unroute_err=0.
  - Applies mid-burst: the burst is abandoned. The slave is expected to be reset with it.
- State machine, IDLE:
  - All S*_Ready=0 and all M*_Valid=0.
  - If any S*_Valid=1: pick a slave (arbitration below), register grant=index and dest=IDS[MID_MSB:MID_LSB] of that slave, go to BUSY.
  - Otherwise stay in IDLE.
- State machine, BUSY:
  - busy=1.
  - dest=0 or 1: M[dest]_* = S[grant]_* combinationally, with ID=IDS[3:0]. S[grant]_Ready = M[dest]_Ready. All other outputs are 0.
  - dest>=2 (unmapped): no master output asserted. S[grant]_Ready=1, so beats are sunk.
  - A beat transfers on S[grant]_Valid & S[grant]_Ready.
  - Beat with Last=1 transfers: next state IDLE and rr_ptr=(grant==2)?0:grant+1. If dest was unmapped, unroute_err=1 in the next cycle only.
- Latency:
  - First beat reaches the master 1 cycle after S_Valid is sampled in IDLE (one grant bubble).
  - Subsequent beats pass with zero latency (combinational forward).
  - Back-to-back bursts cost 1 idle cycle between them.
- Handshake rules:
  - Never assert a master Valid without the granted slave's Valid.
  - A non-granted slave sees Ready=0 and must hold its data.
  - dest is fixed for the whole burst; IDS changes mid-burst are ignored.
- Simultaneous events:
  - Last handshake and a new slave valid in the same cycle: the new grant is decided in the following IDLE cycle.
  - Both masters are never driven at once.
- Single-beat burst (Last on the first beat): BUSY lasts 1 cycle when the master is ready.

Optional Feature:
- Macro: R_ROUTER_RR_EN.
- Defined: round-robin arbitration. The first valid slave at or after rr_ptr wins, searching in cyclic order rr_ptr, rr_ptr+1, ... wrapping modulo 3.
- Undefined: fixed priority S0>S1>S2. rr_ptr is absent; no register remains for it.

Test Plan:
- S1 sends a 4-beat burst, IDS=8'h13, Data=1..4, M1_Ready=1 -> M1_ID=4'h3. M1 sees Data 1..4 on 4 consecutive cycles starting 1 cycle after S1_Valid; M1_Last only on beat 4; M0_Valid stays 0; busy falls the cycle after beat 4.
- S0 sends a 2-beat burst to M0 (IDS=8'h05) with M0_Ready toggling 1,0,1 -> S0_Ready mirrors M0_Ready. Data is held while Ready=0. The burst completes in 3 BUSY cycles.
- S0, S1 and S2 all valid continuously with single-beat bursts -> with R_ROUTER_RR_EN, grant order is 0,1,2,0. Without it, S0 wins every time.
- S2 burst with IDS=8'h27 (unmapped), 3 beats -> S2_Ready=1 on all 3 beats. M0_Valid=M1_Valid=0. unroute_err pulses 1 cycle after the Last beat.
- rst=1 asserted on beat 2 of a 4-beat burst -> next cycle all outputs are 0 and state is IDLE. After release a new S0 valid is granted normally.
- Bursts to M0 (S0) and M1 (S1) pending together -> they are serialized, never overlapping, with exactly 1 idle cycle between S0's Last and S1's first beat.
